// File: rtl/udp_tx.sv
// Ethernet II / IPv4 / UDP frame transmitter: one frame byte per clock from preamble to FCS,
// payload pulled from a first-word-fall-through byte source.
module udp_tx #(
   parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
   parameter logic [47:0] DES_MAC    = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [31:0] BOARD_IP   = 32'hC0A8_000A,
   parameter logic [31:0] DES_IP     = 32'hC0A8_0002,
   parameter logic [15:0] BOARD_PORT = 16'd1234,
   parameter logic [15:0] DES_PORT   = 16'd1234
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start_en,
   input  logic [7:0]  tx_value,
   input  logic [10:0] word_cnt,
   input  logic [31:0] data_sum,
   output logic        tx_done,
   output logic        tx_req,
   output logic [7:0]  tx_data,
   output logic        tx_valid
);

   typedef enum logic [3:0] {
      S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR,
      S_PAYLOAD, S_PAD, S_FCS, S_GAP
   } state_t;

   // state/cnt name the byte that will be registered onto tx_data at the next edge
   state_t      state, state_nx;
   logic [10:0] cnt, cnt_nx;
   logic [10:0] wc_q;
   logic [31:0] sum_q;
   logic [15:0] ip_id, ip_csum, udp_csum;
   logic [31:0] crc;
   logic [7:0]  byte_nx;
   logic        emit, crc_en, last;

   logic [15:0] ip_len, udp_len;
   assign ip_len  = 16'd28 + {5'd0, wc_q};
   assign udp_len = 16'd8  + {5'd0, wc_q};

   logic [19:0] ip_sum;
   logic [16:0] ip_f1;
   logic [15:0] ip_f2;
   logic [33:0] udp_sum;
   logic [18:0] udp_f1;
   logic [16:0] udp_f2;
   logic [15:0] udp_f3, udp_inv;

   always_comb begin
      ip_sum = 20'h04500 + {4'd0, ip_len} + {4'd0, ip_id} + 20'h04000 + 20'h04011
             + {4'd0, BOARD_IP[31:16]} + {4'd0, BOARD_IP[15:0]}
             + {4'd0, DES_IP[31:16]} + {4'd0, DES_IP[15:0]};
      ip_f1  = {1'b0, ip_sum[15:0]} + {13'd0, ip_sum[19:16]};
      ip_f2  = ip_f1[15:0] + {15'd0, ip_f1[16]};

      udp_sum = {2'd0, sum_q}
              + {18'd0, BOARD_IP[31:16]} + {18'd0, BOARD_IP[15:0]}
              + {18'd0, DES_IP[31:16]} + {18'd0, DES_IP[15:0]}
              + 34'h11 + {18'd0, udp_len} + {18'd0, BOARD_PORT}
              + {18'd0, DES_PORT} + {18'd0, udp_len};
      udp_f1  = {3'd0, udp_sum[15:0]} + {1'b0, udp_sum[33:16]};
      udp_f2  = {1'b0, udp_f1[15:0]} + {14'd0, udp_f1[18:16]};
      udp_f3  = udp_f2[15:0] + {15'd0, udp_f2[16]};
      udp_inv = ~udp_f3;
   end

   logic [111:0] eth_hdr;
   logic [159:0] ip_hdr;
   logic [63:0]  udp_hdr;
   logic [31:0]  fcs;
   logic [7:0]   eth_b [0:13];
   logic [7:0]   ip_b  [0:19];
   logic [7:0]   udp_b [0:7];
   logic [7:0]   fcs_b [0:3];

   assign eth_hdr = {DES_MAC, BOARD_MAC, 16'h0800};
   assign ip_hdr  = {16'h4500, ip_len, ip_id, 16'h4000, 8'h40, 8'h11, ip_csum, BOARD_IP, DES_IP};
   assign udp_hdr = {BOARD_PORT, DES_PORT, udp_len, udp_csum};
   assign fcs     = ~crc;

   // headers go out MSB byte first, the FCS LSB byte first
   always_comb begin
      for (int i = 0; i < 14; i++) eth_b[i] = eth_hdr[8*(13-i) +: 8];
      for (int i = 0; i < 20; i++) ip_b[i]  = ip_hdr[8*(19-i) +: 8];
      for (int i = 0; i < 8; i++)  udp_b[i] = udp_hdr[8*(7-i) +: 8];
      for (int i = 0; i < 4; i++)  fcs_b[i] = fcs[8*i +: 8];
   end

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // tx_value is consumed at every edge where tx_req is high; the source must
   // present the next byte in the following cycle.
   assign tx_req = (state == S_PAYLOAD);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 11'd1;
      byte_nx  = 8'h00;
      emit     = 1'b0;
      crc_en   = 1'b0;
      last     = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nx = 11'd0;
            if (tx_start_en) begin
               emit     = 1'b1;
               byte_nx  = 8'h55;
               state_nx = S_PREAMBLE;
               cnt_nx   = 11'd1;
            end
         end
         S_PREAMBLE: begin
            emit    = 1'b1;
            byte_nx = 8'h55;
            if (cnt == 11'd7) begin
               byte_nx  = 8'hD5;
               state_nx = S_ETH_HDR;
               cnt_nx   = 11'd0;
            end
         end
         S_ETH_HDR: begin
            emit    = 1'b1;
            crc_en  = 1'b1;
            byte_nx = eth_b[cnt[3:0]];
            if (cnt == 11'd13) begin
               state_nx = S_IP_HDR;
               cnt_nx   = 11'd0;
            end
         end
         S_IP_HDR: begin
            emit    = 1'b1;
            crc_en  = 1'b1;
            byte_nx = ip_b[cnt[4:0]];
            if (cnt == 11'd19) begin
               state_nx = S_UDP_HDR;
               cnt_nx   = 11'd0;
            end
         end
         S_UDP_HDR: begin
            emit    = 1'b1;
            crc_en  = 1'b1;
            byte_nx = udp_b[cnt[2:0]];
            if (cnt == 11'd7) begin
               state_nx = (wc_q == 11'd0) ? S_PAD : S_PAYLOAD;
               cnt_nx   = 11'd0;
            end
         end
         S_PAYLOAD: begin
            emit    = 1'b1;
            crc_en  = 1'b1;
            byte_nx = tx_value;
            if (cnt == wc_q - 11'd1) begin
               state_nx = (wc_q < 11'd18) ? S_PAD : S_FCS;
               cnt_nx   = 11'd0;
            end
         end
         S_PAD: begin
            emit   = 1'b1;
            crc_en = 1'b1;
            if (cnt == 11'd17 - wc_q) begin
               state_nx = S_FCS;
               cnt_nx   = 11'd0;
            end
         end
         S_FCS: begin
            emit    = 1'b1;
            byte_nx = fcs_b[cnt[1:0]];
            if (cnt == 11'd3) begin
               last     = 1'b1;
               state_nx = S_GAP;
               cnt_nx   = 11'd0;
            end
         end
         S_GAP: begin
            if (cnt == 11'd11) begin
               state_nx = S_IDLE;
               cnt_nx   = 11'd0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = 11'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 11'd0;
         wc_q     <= 11'd0;
         sum_q    <= 32'd0;
         ip_id    <= 16'd0;
         ip_csum  <= 16'd0;
         udp_csum <= 16'd0;
         crc      <= 32'hFFFF_FFFF;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         tx_data  <= byte_nx;
         tx_valid <= emit;
         tx_done  <= last;
         if (state == S_IDLE && tx_start_en) begin
            wc_q  <= word_cnt;
            sum_q <= data_sum;
         end
         // inputs to both checksums are stable from the start edge on
         if (state == S_PREAMBLE) begin
            ip_csum  <= ~ip_f2;
            udp_csum <= (udp_inv == 16'h0000) ? 16'hFFFF : udp_inv;
         end
         if (state == S_IDLE)
            crc <= 32'hFFFF_FFFF;
         else if (crc_en)
            crc <= crc32_byte(crc, byte_nx);
         if (last)
            ip_id <= ip_id + 16'd1;
      end
   end

endmodule

// File: tb/tb_udp_tx.sv
// Bench for udp_tx: a frame-level model builds each expected byte stream and a
// per-cycle expectation queue that one compare process checks on every falling edge.
module tb_udp_tx;

   localparam logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55;
   localparam logic [47:0] DES_MAC    = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [31:0] BOARD_IP   = 32'hC0A8_000A;
   localparam logic [31:0] DES_IP     = 32'hC0A8_0002;
   localparam logic [15:0] BOARD_PORT = 16'd1234;
   localparam logic [15:0] DES_PORT   = 16'd1234;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_start_en = 1'b0;
   logic [7:0]  tx_value;
   logic [10:0] word_cnt = 11'd0;
   logic [31:0] data_sum = 32'd0;
   logic        tx_done, tx_req, tx_valid;
   logic [7:0]  tx_data;

   int          vectors = 0;
   int          miscompares = 0;
   logic [10:0] exp_q[$];      // {valid, req, done, data} per cycle
   logic [7:0]  frm[$];
   logic [7:0]  pay_cnt = 8'd0;
   logic [15:0] exp_id = 16'd0;
   logic [7:0]  src_base = 8'd0;

   always #5 clk = ~clk;

   // first-word-fall-through counter source
   assign tx_value = pay_cnt;
   always @(posedge clk) if (tx_req) pay_cnt <= pay_cnt + 8'd1;

   udp_tx #(
      .BOARD_MAC(BOARD_MAC), .DES_MAC(DES_MAC), .BOARD_IP(BOARD_IP),
      .DES_IP(DES_IP), .BOARD_PORT(BOARD_PORT), .DES_PORT(DES_PORT)
   ) dut (
      .clk(clk), .rst(rst), .tx_start_en(tx_start_en), .tx_value(tx_value),
      .word_cnt(word_cnt), .data_sum(data_sum), .tx_done(tx_done),
      .tx_req(tx_req), .tx_data(tx_data), .tx_valid(tx_valid)
   );

   function automatic logic [15:0] fold_inv(input logic [63:0] s);
      while (s[63:16] != 48'd0) s = {48'd0, s[15:0]} + {16'd0, s[63:16]};
      return ~s[15:0];
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
         else             c = c >> 1;
      end
      return c;
   endfunction

   task automatic push_bytes(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
   endtask

   task automatic build_frame(input int wc, input logic [31:0] ds, input logic [15:0] id,
                              input logic [7:0] base);
      logic [15:0] tl, ul, ipc, udc;
      logic [31:0] crc;
      logic [63:0] s;
      tl = 16'(28 + wc);
      ul = 16'(8 + wc);
      s = 64'h4500 + 64'(tl) + 64'(id) + 64'h4000 + 64'h4011
        + 64'(BOARD_IP[31:16]) + 64'(BOARD_IP[15:0]) + 64'(DES_IP[31:16]) + 64'(DES_IP[15:0]);
      ipc = fold_inv(s);
      s = 64'(ds) + 64'(BOARD_IP[31:16]) + 64'(BOARD_IP[15:0]) + 64'(DES_IP[31:16])
        + 64'(DES_IP[15:0]) + 64'h11 + 64'(ul) + 64'(BOARD_PORT) + 64'(DES_PORT) + 64'(ul);
      udc = fold_inv(s);
      if (udc == 16'h0000) udc = 16'hFFFF;
      frm.delete();
      repeat (7) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      push_bytes(64'(DES_MAC), 6);
      push_bytes(64'(BOARD_MAC), 6);
      push_bytes(64'h0800, 2);
      push_bytes(64'h4500, 2);
      push_bytes(64'(tl), 2);
      push_bytes(64'(id), 2);
      push_bytes(64'h4000, 2);
      push_bytes(64'h4011, 2);
      push_bytes(64'(ipc), 2);
      push_bytes(64'(BOARD_IP), 4);
      push_bytes(64'(DES_IP), 4);
      push_bytes(64'(BOARD_PORT), 2);
      push_bytes(64'(DES_PORT), 2);
      push_bytes(64'(ul), 2);
      push_bytes(64'(udc), 2);
      for (int n = 0; n < wc; n++) frm.push_back(8'(int'(base) + n));
      for (int n = wc; n < 18; n++) frm.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < frm.size(); i++) crc = crc_upd(crc, frm[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // start sampled at the next rising edge; returns just after the edge preceding
   // the first one at which the transmitter is idle again
   task automatic send_frame(input int wc, input logic [31:0] ds, input bit keep);
      int len;
      build_frame(wc, ds, exp_id, src_base);
      len = frm.size();
      word_cnt    = 11'(wc);
      data_sum    = ds;
      tx_start_en = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) tx_start_en = 1'b0;
      for (int c = 0; c < len; c++)
         exp_q.push_back({1'b1, (c >= 49 && c < 49 + wc), (c == len - 1), frm[c]});
      repeat (12) exp_q.push_back(11'd0);
      exp_id   = exp_id + 16'd1;
      src_base = 8'(int'(src_base) + wc);
      repeat (len + 11) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [10:0] e, a;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'd0;
      a = {tx_valid, tx_req, tx_done, tx_data};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got v/req/done/data %b/%b/%b/%02h, expected %b/%b/%b/%02h",
                  $time, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
      end
   end

   initial begin
      logic [31:0] c;
      logic [7:0]  s9 [0:8];
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // pin the model with hand-computed literals
      for (int i = 0; i < 9; i++) s9[i] = 8'(8'h31 + i);
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) c = crc_upd(c, s9[i]);
      check("model_crc_123456789", ~c, 32'hCBF4_3926);
      build_frame(15, 32'h1234_5678, 16'h0000, 8'h00);
      check("model_len_wc15", frm.size(), 72);
      check("model_ip_csum", {frm[32], frm[33]}, 32'h0000_B965);
      check("model_udp_csum", {frm[48], frm[49]}, 32'h0000_0C13);
      check("model_ip_totlen", {frm[24], frm[25]}, 32'h0000_002B);
      check("model_udp_len", {frm[46], frm[47]}, 32'h0000_0017);
      check("model_pad_first", {frm[65], frm[66], frm[67]}, 32'h0);
      build_frame(0, 32'h0, 16'h0002, 8'h00);
      check("model_udp_len_wc0", {frm[46], frm[47]}, 32'h0000_0008);

      // two back-to-back frames with start held through the gap
      send_frame(15, 32'h1234_5678, 1'b1);
      send_frame(15, 32'h1234_5678, 1'b0);
      check("src_after_two", pay_cnt, 32'd30);
      repeat (5) @(posedge clk);
      #1;

      send_frame(0, 32'h0000_0000, 1'b0);
      check("src_after_wc0", pay_cnt, 32'd30);
      send_frame(100, 32'hDEAD_BEEF, 1'b0);
      check("src_after_wc100", pay_cnt, 32'd130);
      repeat (3) @(posedge clk);
      #1;

      // abort at byte 30, then a fresh frame with identification restarted
      build_frame(40, 32'h0000_0000, exp_id, src_base);
      word_cnt    = 11'd40;
      tx_start_en = 1'b1;
      @(posedge clk);
      #1 tx_start_en = 1'b0;
      for (int b = 0; b < 30; b++) exp_q.push_back({3'b100, frm[b]});
      repeat (30) @(posedge clk);
      #1 check("abort_byte30_valid", tx_valid, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("abort_valid", tx_valid, 32'd0);
      check("abort_data", tx_data, 32'd0);
      check("abort_req", tx_req, 32'd0);
      check("abort_done", tx_done, 32'd0);
      exp_q.delete();
      exp_id = 16'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_frame(5, 32'h0000_0102, 1'b0);
      repeat (4) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
